// File: rtl/l2_store_responder.sv
// ============================================================================
// l2_store_responder
// Responder end of the L1 store-queue / L2 protocol. Buffers store, sync-store,
// flush and invalidate requests, commits stores to the L2 write port after a
// fixed latency and returns one tagged response per accepted request.
// Optional feature macro: L2_SYNC_RESERVATION_EN (per-thread load-linked
// reservation table; when undefined every sync store succeeds).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_store_responder #(
  parameter int FIFO_DEPTH       = 4,
  parameter int RESPONSE_LATENCY = 2,
  parameter int THREADS_PER_CORE = 4,
  parameter int ADDR_WIDTH       = 26,
  parameter int CACHE_LINE_BYTES = 64,
  localparam int TAG_WIDTH  = (THREADS_PER_CORE > 1) ? $clog2(THREADS_PER_CORE) : 1,
  localparam int DATA_WIDTH = CACHE_LINE_BYTES * 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sq_dequeue_ready,
  input  logic [ADDR_WIDTH-1:0]       sq_dequeue_addr,
  input  logic [TAG_WIDTH-1:0]        sq_dequeue_idx,
  input  logic [CACHE_LINE_BYTES-1:0] sq_dequeue_mask,
  input  logic [DATA_WIDTH-1:0]       sq_dequeue_data,
  input  logic                        sq_dequeue_sync,
  input  logic                        sq_dequeue_flush,
  input  logic                        sq_dequeue_iinvalidate,
  input  logic                        sq_dequeue_dinvalidate,
  output logic                        storebuf_dequeue_ack,
  input  logic                        ll_en,
  input  logic [TAG_WIDTH-1:0]        ll_thread_idx,
  input  logic [ADDR_WIDTH-1:0]       ll_addr,
  output logic                        storebuf_l2_response_valid,
  output logic [TAG_WIDTH-1:0]        storebuf_l2_response_idx,
  output logic                        storebuf_l2_sync_success,
  output logic                        l2_write_en,
  output logic [ADDR_WIDTH-1:0]       l2_write_addr,
  output logic [CACHE_LINE_BYTES-1:0] l2_write_mask,
  output logic [DATA_WIDTH-1:0]       l2_write_data
);

  localparam int IDX_WIDTH = $clog2(FIFO_DEPTH);
  localparam int PTR_WIDTH = IDX_WIDTH + 1;
  localparam int CNT_WIDTH = $clog2(RESPONSE_LATENCY + 1);
  // WAIT occupies RESPONSE_LATENCY-1 cycles, so the counter starts one short
  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD =
    (RESPONSE_LATENCY > 1) ? CNT_WIDTH'(RESPONSE_LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Request FIFO
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0]       fifo_addr  [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]        fifo_tag   [FIFO_DEPTH];
  logic [CACHE_LINE_BYTES-1:0] fifo_mask  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]       fifo_data  [FIFO_DEPTH];
  logic [3:0]                  fifo_kind  [FIFO_DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  assign fifo_full  = (wr_ptr[PTR_WIDTH-1] != rd_ptr[PTR_WIDTH-1]) &&
                      (wr_ptr[PTR_WIDTH-2:0] == rd_ptr[PTR_WIDTH-2:0]);
  assign fifo_empty = (wr_ptr == rd_ptr);

  // Acceptance never bypasses a full buffer, even when a pop is under way
  assign storebuf_dequeue_ack = reset && sq_dequeue_ready && !fifo_full;
  assign push                 = storebuf_dequeue_ack;

  // FIFO pointer update; pointers carry one wrap bit beyond the index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
    end
  end

  // FIFO storage write; contents are meaningless until the pointers cover them
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[IDX_WIDTH-1:0]] <= sq_dequeue_addr;
      fifo_tag [wr_ptr[IDX_WIDTH-1:0]] <= sq_dequeue_idx;
      fifo_mask[wr_ptr[IDX_WIDTH-1:0]] <= sq_dequeue_mask;
      fifo_data[wr_ptr[IDX_WIDTH-1:0]] <= sq_dequeue_data;
      fifo_kind[wr_ptr[IDX_WIDTH-1:0]] <= {sq_dequeue_dinvalidate, sq_dequeue_iinvalidate,
                                           sq_dequeue_flush, sq_dequeue_sync};
    end
  end

  // --------------------------------------------------------------------------
  // Head register and processing FSM
  // --------------------------------------------------------------------------
  state_t                state;
  state_t                next_state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cnt_next;

  logic [ADDR_WIDTH-1:0]       head_addr;
  logic [TAG_WIDTH-1:0]        head_tag;
  logic [CACHE_LINE_BYTES-1:0] head_mask;
  logic [DATA_WIDTH-1:0]       head_data;
  logic                        head_sync;
  logic                        head_flush;
  logic                        head_iinv;
  logic                        head_dinv;

  // State and latency counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: pop in IDLE, count down in WAIT, one-cycle COMMIT
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (RESPONSE_LATENCY == 1) begin
            next_state = S_COMMIT;
          end else begin
            next_state = S_WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) next_state = S_COMMIT;
        else           cnt_next   = cnt - CNT_WIDTH'(1);
      end
      S_COMMIT: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Head register captures the popped entry; cleared so reset outputs read 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_addr  <= '0;
      head_tag   <= '0;
      head_mask  <= '0;
      head_data  <= '0;
      head_sync  <= 1'b0;
      head_flush <= 1'b0;
      head_iinv  <= 1'b0;
      head_dinv  <= 1'b0;
    end else if (pop) begin
      head_addr  <= fifo_addr[rd_ptr[IDX_WIDTH-1:0]];
      head_tag   <= fifo_tag [rd_ptr[IDX_WIDTH-1:0]];
      head_mask  <= fifo_mask[rd_ptr[IDX_WIDTH-1:0]];
      head_data  <= fifo_data[rd_ptr[IDX_WIDTH-1:0]];
      {head_dinv, head_iinv, head_flush, head_sync} <= fifo_kind[rd_ptr[IDX_WIDTH-1:0]];
    end
  end

  // --------------------------------------------------------------------------
  // Commit outputs (registered sources only)
  // --------------------------------------------------------------------------
  logic is_commit;
  logic head_store;
  logic sync_ok;

  assign is_commit  = (state == S_COMMIT);
  assign head_store = !(head_sync || head_flush || head_iinv || head_dinv);

  assign storebuf_l2_response_valid = is_commit;
  assign storebuf_l2_response_idx   = is_commit ? head_tag : '0;
  assign storebuf_l2_sync_success   = is_commit && head_sync && sync_ok;
  assign l2_write_en                = is_commit && (head_store || (head_sync && sync_ok));
  assign l2_write_addr              = head_addr;
  assign l2_write_mask              = head_mask;
  assign l2_write_data              = head_data;

`ifdef L2_SYNC_RESERVATION_EN
  // --------------------------------------------------------------------------
  // Per-thread load-linked reservations
  // --------------------------------------------------------------------------
  logic [THREADS_PER_CORE-1:0] res_valid;
  logic [ADDR_WIDTH-1:0]       res_addr [THREADS_PER_CORE];
  logic                        res_kill;

  assign sync_ok  = res_valid[head_tag] && (res_addr[head_tag] == head_addr);
  // A committed write or a dinvalidate retires every reservation on the line
  assign res_kill = l2_write_en || (is_commit && head_dinv);

  // Reservation update: address-match clear first, then ll_en set wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid <= '0;
      for (int t = 0; t < THREADS_PER_CORE; t++) res_addr[t] <= '0;
    end else begin
      for (int t = 0; t < THREADS_PER_CORE; t++) begin
        if (res_kill && res_valid[t] && (res_addr[t] == head_addr)) res_valid[t] <= 1'b0;
      end
      if (ll_en) begin
        res_valid[ll_thread_idx] <= 1'b1;
        res_addr[ll_thread_idx]  <= ll_addr;
      end
    end
  end
`else
  // Without reservation tracking every sync store commits
  logic unused_ll;
  assign sync_ok   = 1'b1;
  assign unused_ll = ^{ll_en, ll_thread_idx, ll_addr};
`endif

endmodule

`default_nettype wire

// File: doc/l2_store_responder.md
# l2_store_responder

Responder end of the L1 store-queue/L2 protocol. Accepts store, synchronized-store, flush and invalidate requests offered by one core's store queue, buffers them, and commits stores to the L2 data write port. Tracks per-thread load-linked reservations to resolve synchronized stores, and returns exactly one tagged response per accepted request after a fixed processing latency. Sits between the core's l1_l2_interface request path and the L2 data array.

## Interface
- FIFO_DEPTH, 4: request buffer entries; power of two, at least 2.
- RESPONSE_LATENCY, 2: cycles from pop to commit; at least 1.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- sq_dequeue_ready  in  1  request offered.
- sq_dequeue_addr  in  cache_line_index_t  line address.
- sq_dequeue_idx  in  l1_miss_entry_idx_t  requester tag, returned with the response.
- sq_dequeue_mask  in  CACHE_LINE_BYTES  byte enables.
- sq_dequeue_data  in  cache_line_data_t  store data.
- sq_dequeue_sync / sq_dequeue_flush / sq_dequeue_iinvalidate / sq_dequeue_dinvalidate  in  1 each  request kind; at most one is set; none set means plain store.
- storebuf_dequeue_ack  out  1  request accepted this cycle.
- ll_en  in  1  synchronized load issued.
- ll_thread_idx  in  local_thread_idx_t  thread of the synchronized load.
- ll_addr  in  cache_line_index_t  address of the synchronized load.
- storebuf_l2_response_valid  out  1  response pulse.
- storebuf_l2_response_idx  out  l1_miss_entry_idx_t  tag of the completed request.
- storebuf_l2_sync_success  out  1  synchronized store succeeded.
- l2_write_en  out  1  commit pulse.
- l2_write_addr  out  cache_line_index_t  commit address.
- l2_write_mask  out  CACHE_LINE_BYTES  commit byte enables.
- l2_write_data  out  cache_line_data_t  commit data.

## Operation
- Acceptance:
  - storebuf_dequeue_ack = sq_dequeue_ready && !fifo_full. This is combinational, same cycle as the offer.
  - On ack, the full request is pushed. No bypass when full, even if a pop occurs in the same cycle.
- The thread that issued a request is the value of sq_dequeue_idx (the tag is the local thread index).
- FSM states are IDLE, WAIT and COMMIT.
  - IDLE with FIFO non-empty: pop the head into the head register. If RESPONSE_LATENCY == 1, go to COMMIT; otherwise load the counter with RESPONSE_LATENCY-2 and go to WAIT.
  - WAIT: when the counter reaches 0, go to COMMIT; otherwise decrement.
  - COMMIT: drive outputs for one cycle, then go to IDLE.
- COMMIT outputs:
  - storebuf_l2_response_valid = 1 and response_idx = the head's tag.
  - Plain store: l2_write_en = 1.
  - Sync store: success = reservation[tag].valid && reservation[tag].addr == head addr. l2_write_en = success, and storebuf_l2_sync_success = success.
  - Flush and iinvalidate: response only; no write, no reservation effect.
  - dinvalidate: response only; clears every reservation whose address matches.
  - storebuf_l2_sync_success = 0 for every non-sync request.
- Reservations, one entry per THREADS_PER_CORE thread:
  - ll_en sets valid and addr for ll_thread_idx.
  - Any committed write (l2_write_en) to address A clears all reservations for A, including the writer's own.
  - The same-cycle conflict is resolved in favour of ll_en: the clear is applied first, then the set.
- All l2_write_* and response outputs are driven only from the state register and head register; no input-to-output combinational path exists.

## Timing
- Reset values:
  - ack and l2_write_en follow their definitions and are 0 while reset is asserted.
  - response_valid = 0, response_idx = 0, sync_success = 0.
  - l2_write_addr, l2_write_mask and l2_write_data = 0.
  - FIFO empty, all reservations invalid, FSM in IDLE.
- Reset asserted mid-operation discards the FIFO, the head and all reservations; no response is issued.
- Latency with no backlog: ack in cycle A, pop in A+1, response and write in A+1+RESPONSE_LATENCY.
- Throughput: one request per RESPONSE_LATENCY+1 cycles. The FIFO absorbs bursts of up to FIFO_DEPTH.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2×FIFO_DEPTH.
  - full = indexes equal with MSBs differing.
  - empty = pointers equal.
- Simultaneous push and pop are allowed when the FIFO is not full.

## Configuration
- L2_SYNC_RESERVATION_EN defined: reservation table and sync resolution exactly as described above.
- L2_SYNC_RESERVATION_EN undefined:
  - No reservation storage; ll_* inputs are ignored.
  - Every sync store commits, and storebuf_l2_sync_success = 1.

## Test plan
- Plain store, defaults, idle: offer addr 0x40, mask all-ones, tag 2 in cycle 0. Required: ack in cycle 0; in cycle 3, write_en = 1 at addr 0x40 and response_valid = 1 with idx 2 and sync_success 0.
- Five back-to-back offers (FIFO_DEPTH = 4, RESPONSE_LATENCY = 2). Required: ack in cycles 0–3; the fifth offer is not acked until after the first pop; responses in cycles 3, 6, 9, 12, 15 in tag order.
- Reservation success and loss:
  - ll_en, thread 1, addr 0x80, then a sync store from tag 1 to 0x80: success 1, write occurs.
  - A second sync store from tag 1 to 0x80: success 0, no write, because the first commit cleared the reservation.
- Cross-thread conflict: reservations are held by threads 0 and 3 at 0x100. A plain store to 0x100 commits. A following sync store from tag 3 to 0x100 then fails with success 0.
- Cache control: a dinvalidate to 0xC0 with a reservation held by thread 2 at 0xC0. Required: response and no write; a later sync store from tag 2 fails. A flush to 0xC0 gives a response only, with write_en = 0.
- Reset mid-WAIT: assert reset with two entries queued. Required: all outputs 0, no response after release, and a new request completes with normal latency. Repeat the sync test with L2_SYNC_RESERVATION_EN undefined: the sync store always succeeds.
